// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_seq sequencer: phase encoding, default PCs, instruction width.
package cpu_pkg;

    localparam int          CPU_ILEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] CPU_TRAP_PC  = 32'h0000_0010;

    localparam logic [2:0] PH_FETCH   = 3'd0;
    localparam logic [2:0] PH_DECODE  = 3'd1;
    localparam logic [2:0] PH_READ    = 3'd2;
    localparam logic [2:0] PH_EXEC    = 3'd3;
    localparam logic [2:0] PH_MEM     = 3'd4;
    localparam logic [2:0] PH_WB      = 3'd5;
    localparam logic [2:0] PH_UPDATE  = 3'd6;
    // TRAP and HALT share one code; the sequencer's halted flag tells them apart.
    localparam logic [2:0] PH_SPECIAL = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH   = PH_FETCH,
        ST_DECODE  = PH_DECODE,
        ST_READ    = PH_READ,
        ST_EXEC    = PH_EXEC,
        ST_MEM     = PH_MEM,
        ST_WB      = PH_WB,
        ST_UPDATE  = PH_UPDATE,
        ST_SPECIAL = PH_SPECIAL
    } seq_state_e;

endpackage

// File: rtl/cpu_seq_pc.sv
// PC register for cpu_seq: next-PC mux (branch target or pc+4) and target alignment check.
module cpu_seq_pc
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(CPU_TRAP_PC),
    parameter int              PC_ALIGN = 2
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_upd,
    input  logic            i_trap_ld,
    input  logic            i_taken,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_pc,
    output logic            o_misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << PC_ALIGN) - 64'd1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;

    assign w_next_pc  = i_taken ? i_target : r_pc + XLEN'(4);
    assign o_misalign = i_taken && ((i_target & ALIGN_MASK) != '0);

    // A misaligned target leaves pc untouched; the trap redirect loads TRAP_PC later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_trap_ld) begin
            r_pc <= TRAP_PC;
        end else if (i_upd && !o_misalign) begin
            r_pc <= w_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle control sequencer for the RV32I core: phase FSM, memory handshakes, trap/halt.
// Optional perf counters (cycle_cnt, instret_cnt) when CPU_SEQ_PERF_EN is defined.
//
// state   | meaning
// FETCH   | imem_req held until imem_ack
// DECODE  | dec_en strobe, illegal sampled
// READ    | rf_rd_en strobe
// EXEC    | alu_en strobe, is_load/is_store sampled
// MEM     | dmem_req held until dmem_ack
// WB      | wb_en strobe
// UPDATE  | pc written or misaligned-target trap, halt_req sampled
// SPECIAL | TRAP (halted=0, trap pulse, pc<=TRAP_PC) or HALT (halted=1)
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(CPU_TRAP_PC),
    parameter int              PC_ALIGN = 2
)(
    input  logic            CLK100MHZ,
    input  logic            rst_n,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            illegal,
    input  logic            taken_branch,
    input  logic [XLEN-1:0] target,
    input  logic            halt_req,
    output logic [2:0]      phase,
    output logic            dec_en,
    output logic            rf_rd_en,
    output logic            alu_en,
    output logic            wb_en,
    output logic [XLEN-1:0] pc,
    output logic            trap,
    output logic            halted
`ifdef CPU_SEQ_PERF_EN
   ,output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);

    seq_state_e r_state;
    logic       r_halted;
    logic       r_imem_req;
    logic       r_dmem_req;
    logic       r_dec_en;
    logic       r_rf_rd_en;
    logic       r_alu_en;
    logic       r_wb_en;
    logic       r_trap;

    logic       w_upd;
    logic       w_trap_ld;
    logic       w_misalign;

    assign w_upd     = (r_state == ST_UPDATE);
    assign w_trap_ld = (r_state == ST_SPECIAL) && !r_halted;

    cpu_seq_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC),
        .PC_ALIGN (PC_ALIGN)
    ) u_pc (
        .i_clk      (CLK100MHZ),
        .i_rst_n    (rst_n),
        .i_upd      (w_upd),
        .i_trap_ld  (w_trap_ld),
        .i_taken    (taken_branch),
        .i_target   (target),
        .o_pc       (pc),
        .o_misalign (w_misalign)
    );

    // Outputs are registered from the next state, so each strobe lines up with its phase.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_halted   <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dec_en   <= 1'b0;
            r_rf_rd_en <= 1'b0;
            r_alu_en   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_dec_en   <= 1'b0;
            r_rf_rd_en <= 1'b0;
            r_alu_en   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_trap     <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_dec_en   <= 1'b1;
                        r_state    <= ST_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (illegal) begin
                        r_trap   <= 1'b1;
                        r_halted <= 1'b0;
                        r_state  <= ST_SPECIAL;
                    end else begin
                        r_rf_rd_en <= 1'b1;
                        r_state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_alu_en <= 1'b1;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_load || is_store) begin
                        r_dmem_req <= 1'b1;
                        r_state    <= ST_MEM;
                    end else begin
                        r_wb_en <= 1'b1;
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_wb_en    <= 1'b1;
                        r_state    <= ST_WB;
                    end else begin
                        r_dmem_req <= 1'b1;
                    end
                end
                ST_WB: begin
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (w_misalign) begin
                        r_trap   <= 1'b1;
                        r_halted <= 1'b0;
                        r_state  <= ST_SPECIAL;
                    end else if (halt_req) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_SPECIAL;
                    end else begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_SPECIAL: begin
                    if (!r_halted || !halt_req) begin
                        r_halted   <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign phase    = r_state;
    assign imem_req = r_imem_req;
    assign dmem_req = r_dmem_req;
    assign dec_en   = r_dec_en;
    assign rf_rd_en = r_rf_rd_en;
    assign alu_en   = r_alu_en;
    assign wb_en    = r_wb_en;
    assign trap     = r_trap;
    assign halted   = r_halted;

`ifdef CPU_SEQ_PERF_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= 64'd0;
            r_instret_cnt <= 64'd0;
        end else begin
            if (!((r_state == ST_SPECIAL) && r_halted)) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
            if (w_upd && !w_misalign) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule
